// File: rtl/csi_rx_packet_handler_mvc.sv
// CSI-2 packet layer: header ECC check, per-VC frame/line tracking and long-packet payload
// forwarding with byte-valid qualifiers, plus sync_wait / packet_done handshakes for the lane front end.
module csi_rx_packet_handler_mvc #(
  parameter int          NUM_VC    = 4,
  parameter logic [5:0]  FS_DT     = 6'h00,
  parameter logic [5:0]  FE_DT     = 6'h01,
  parameter logic [5:0]  LS_DT     = 6'h02,
  parameter logic [5:0]  LE_DT     = 6'h03,
  parameter logic [63:0] DT_ACCEPT = 64'h0000_1C00_0000_0000,
  parameter bit          ECC_CHECK = 1'b1,
  parameter int          MAX_LEN   = 8192
) (
  input  logic              clock_i,
  input  logic              areset_n_i,
  input  logic [31:0]       data_i,
  input  logic              data_enable_i,
  input  logic              data_frame_i,
  input  logic              lp_detect_i,
  output logic              sync_wait_o,
  output logic              packet_done_o,
  output logic [31:0]       payload_o,
  output logic [3:0]        payload_valid_o,
  output logic              payload_enable_o,
  output logic [1:0]        payload_vc_o,
  output logic [5:0]        payload_dt_o,
  output logic              payload_last_o,
  output logic              frame_start_o,
  output logic              frame_end_o,
  output logic [NUM_VC-1:0] in_frame_o,
  output logic              in_line_o,
  output logic [15:0]       line_num_o,
  output logic [15:0]       frame_num_o,
  output logic [7:0]        ecc_err_cnt_o,
  output logic [7:0]        timeout_cnt_o
);

  localparam int WORD_LIMIT = MAX_LEN / 4;

  typedef enum logic [1:0] {S_SYNC, S_PAYLOAD, S_SKIP, S_DONE} state_t;

  state_t      state_q;
  logic        sync_wait_q, packet_done_q, payload_enable_q, payload_last_q;
  logic        frame_start_q, frame_end_q, in_line_q;
  logic [31:0] payload_q;
  logic [3:0]  payload_valid_q;
  logic [1:0]  payload_vc_q;
  logic [5:0]  payload_dt_q;
  logic [3:0]  in_frame_q;
  logic [15:0] line_q [4];
  logic [15:0] frame_num_q, rem_q, wcnt_q;
  logic [7:0]  ecc_err_q, timeout_q;

  logic [23:0] d;
  logic [5:0]  ecc_calc, hdr_dt;
  logic [1:0]  hdr_vc;
  logic [15:0] hdr_wc, rem_d;
  logic        hdr_ecc_ok, hdr_vc_ok, hdr_is_sync;
  logic        word_valid, is_last, timed_out, accept_word, abort_now;
  logic [3:0]  last_valid;

  assign d      = data_i[23:0];
  assign hdr_vc = data_i[7:6];
  assign hdr_dt = data_i[5:0];
  assign hdr_wc = data_i[23:8];

  // CSI-2 24-bit Hamming parity; P7:P6 must be zero and no correction is attempted.
  assign ecc_calc[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
  assign ecc_calc[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
  assign ecc_calc[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
  assign ecc_calc[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
  assign ecc_calc[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
  assign ecc_calc[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];

  assign hdr_ecc_ok  = (ECC_CHECK == 1'b0) || (data_i[31:24] == {2'b00, ecc_calc});
  assign hdr_vc_ok   = (int'(hdr_vc) < NUM_VC);
  assign hdr_is_sync = (hdr_dt == FS_DT) || (hdr_dt == FE_DT) || (hdr_dt == LS_DT) || (hdr_dt == LE_DT);

  assign word_valid = data_enable_i && data_frame_i;
  assign is_last    = (rem_q <= 16'd4);
  assign timed_out  = (int'(wcnt_q) >= WORD_LIMIT);
  assign rem_d      = is_last ? 16'd0 : (rem_q - 16'd4);

  always_comb begin
    last_valid = 4'b1111;
    case (rem_q)
      16'd1:   last_valid = 4'b0001;
      16'd2:   last_valid = 4'b0011;
      16'd3:   last_valid = 4'b0111;
      default: last_valid = 4'b1111;
    endcase
  end

  // A final word beats a coincident lp_detect; any other lp_detect, frame drop or overlong packet aborts.
  assign accept_word = word_valid && !timed_out && (is_last || !lp_detect_i);
  assign abort_now   = !accept_word && (lp_detect_i || (data_enable_i && (!data_frame_i || timed_out)));

  always_ff @(posedge clock_i or negedge areset_n_i) begin
    if (!areset_n_i) begin
      state_q          <= S_SYNC;
      sync_wait_q      <= 1'b1;
      packet_done_q    <= 1'b0;
      payload_enable_q <= 1'b0;
      payload_last_q   <= 1'b0;
      frame_start_q    <= 1'b0;
      frame_end_q      <= 1'b0;
      in_line_q        <= 1'b0;
      payload_q        <= '0;
      payload_valid_q  <= '0;
      payload_vc_q     <= '0;
      payload_dt_q     <= '0;
      in_frame_q       <= '0;
      frame_num_q      <= '0;
      rem_q            <= '0;
      wcnt_q           <= '0;
      ecc_err_q        <= '0;
      timeout_q        <= '0;
      for (int i = 0; i < 4; i++) line_q[i] <= '0;
    end else begin
      packet_done_q    <= 1'b0;
      payload_enable_q <= 1'b0;
      payload_last_q   <= 1'b0;
      payload_valid_q  <= 4'b0000;
      frame_start_q    <= 1'b0;
      frame_end_q      <= 1'b0;
      case (state_q)
        S_SYNC: begin
          if (word_valid) begin
            sync_wait_q <= 1'b0;
            if (!hdr_ecc_ok) begin
              ecc_err_q     <= (ecc_err_q == 8'hFF) ? ecc_err_q : ecc_err_q + 8'd1;
              state_q       <= S_DONE;
              packet_done_q <= 1'b1;
            end else if (hdr_dt < 6'h10) begin
              state_q       <= S_DONE;
              packet_done_q <= 1'b1;
              if (hdr_vc_ok && hdr_is_sync) payload_vc_q <= hdr_vc;
              if (hdr_vc_ok && hdr_dt == FS_DT) begin
                in_frame_q[hdr_vc] <= 1'b1;
                line_q[hdr_vc]     <= '0;
                frame_num_q        <= hdr_wc;
                frame_start_q      <= 1'b1;
              end
              if (hdr_vc_ok && hdr_dt == FE_DT) begin
                in_frame_q[hdr_vc] <= 1'b0;
                frame_end_q        <= 1'b1;
              end
            end else begin
              rem_q  <= hdr_wc;
              wcnt_q <= '0;
              if (hdr_wc == 16'd0) begin
                state_q       <= S_DONE;
                packet_done_q <= 1'b1;
              end else if (DT_ACCEPT[hdr_dt] && hdr_vc_ok) begin
                payload_vc_q <= hdr_vc;
                payload_dt_q <= hdr_dt;
                in_line_q    <= 1'b1;
                state_q      <= S_PAYLOAD;
              end else begin
                state_q <= S_SKIP;
              end
            end
          end
        end
        S_PAYLOAD, S_SKIP: begin
          if (accept_word) begin
            wcnt_q <= wcnt_q + 16'd1;
            rem_q  <= rem_d;
            if (state_q == S_PAYLOAD) begin
              payload_q        <= data_i;
              payload_enable_q <= 1'b1;
              payload_valid_q  <= is_last ? last_valid : 4'b1111;
              payload_last_q   <= is_last;
            end
            if (is_last) begin
              state_q       <= S_DONE;
              packet_done_q <= 1'b1;
              if (state_q == S_PAYLOAD) begin
                in_line_q            <= 1'b0;
                line_q[payload_vc_q] <= line_q[payload_vc_q] + 16'd1;
              end
            end
          end else if (abort_now) begin
            timeout_q     <= (timeout_q == 8'hFF) ? timeout_q : timeout_q + 8'd1;
            in_line_q     <= 1'b0;
            state_q       <= S_DONE;
            packet_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q     <= S_SYNC;
          sync_wait_q <= 1'b1;
        end
        default: state_q <= S_SYNC;
      endcase
    end
  end

  assign sync_wait_o      = sync_wait_q;
  assign packet_done_o    = packet_done_q;
  assign payload_o        = payload_q;
  assign payload_valid_o  = payload_valid_q;
  assign payload_enable_o = payload_enable_q;
  assign payload_vc_o     = payload_vc_q;
  assign payload_dt_o     = payload_dt_q;
  assign payload_last_o   = payload_last_q;
  assign frame_start_o    = frame_start_q;
  assign frame_end_o      = frame_end_q;
  assign in_frame_o       = in_frame_q[NUM_VC-1:0];
  assign in_line_o        = in_line_q;
  assign line_num_o       = line_q[payload_vc_q];
  assign frame_num_o      = frame_num_q;
  assign ecc_err_cnt_o    = ecc_err_q;
  assign timeout_cnt_o    = timeout_q;

endmodule

// File: tb/tb_csi_rx_packet_handler_mvc.sv
// Randomized bench for csi_rx_packet_handler_mvc: packet-level reference model, one task per scenario.
module tb_csi_rx_packet_handler_mvc;

  localparam int NUM_VC  = 2;
  localparam int MAX_LEN = 64;
  localparam int LIMIT   = MAX_LEN / 4;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  v;
    logic        last;
    logic [1:0]  vc;
    logic [5:0]  dt;
  } pw_t;

  logic        clock, areset_n, data_enable, data_frame, lp_detect;
  logic [31:0] data;
  logic        sync_wait_o, packet_done_o, payload_enable_o, payload_last_o;
  logic        frame_start_o, frame_end_o, in_line_o;
  logic [31:0] payload_o;
  logic [3:0]  payload_valid_o;
  logic [1:0]  payload_vc_o;
  logic [5:0]  payload_dt_o;
  logic [NUM_VC-1:0] in_frame_o;
  logic [15:0] line_num_o, frame_num_o;
  logic [7:0]  ecc_err_cnt_o, timeout_cnt_o;

  csi_rx_packet_handler_mvc #(.NUM_VC(NUM_VC), .MAX_LEN(MAX_LEN)) dut (
    .clock_i(clock), .areset_n_i(areset_n), .data_i(data), .data_enable_i(data_enable),
    .data_frame_i(data_frame), .lp_detect_i(lp_detect), .sync_wait_o(sync_wait_o),
    .packet_done_o(packet_done_o), .payload_o(payload_o), .payload_valid_o(payload_valid_o),
    .payload_enable_o(payload_enable_o), .payload_vc_o(payload_vc_o), .payload_dt_o(payload_dt_o),
    .payload_last_o(payload_last_o), .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
    .in_frame_o(in_frame_o), .in_line_o(in_line_o), .line_num_o(line_num_o),
    .frame_num_o(frame_num_o), .ecc_err_cnt_o(ecc_err_cnt_o), .timeout_cnt_o(timeout_cnt_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_in_frame [4];
  logic [15:0] m_line [4];
  logic [15:0] m_frame_num;
  int          m_ecc, m_to, exp_done, exp_fs, exp_fe;
  pw_t         exp_q [$];

  // Observed activity
  pw_t obs_q [$];
  int  done_cnt = 0, fs_cnt = 0, fe_cnt = 0;

  always @(negedge clock) begin
    if (payload_enable_o) obs_q.push_back({payload_o, payload_valid_o, payload_last_o, payload_vc_o, payload_dt_o});
    if (packet_done_o) done_cnt++;
    if (frame_start_o) fs_cnt++;
    if (frame_end_o) fe_cnt++;
  end

  // Hamming column code of each header data bit (P5..P0)
  function automatic logic [5:0] ecc_col(int i);
    case (i)
      0: return 6'h07;  1: return 6'h0B;  2: return 6'h0D;  3: return 6'h0E;
      4: return 6'h13;  5: return 6'h15;  6: return 6'h16;  7: return 6'h19;
      8: return 6'h1A;  9: return 6'h1C; 10: return 6'h23; 11: return 6'h25;
     12: return 6'h26; 13: return 6'h29; 14: return 6'h2A; 15: return 6'h2C;
     16: return 6'h31; 17: return 6'h32; 18: return 6'h34; 19: return 6'h38;
     20: return 6'h1F; 21: return 6'h2F; 22: return 6'h37; default: return 6'h3B;
    endcase
  endfunction

  function automatic logic [31:0] mk_hdr(logic [1:0] vc, logic [5:0] dt, logic [15:0] wc);
    logic [23:0] dd;
    logic [5:0]  e;
    dd = {wc, vc, dt};
    e  = 6'h00;
    for (int i = 0; i < 24; i++) if (dd[i]) e = e ^ ecc_col(i);
    return {2'b00, e, dd};
  endfunction

  function automatic logic [3:0] byte_mask(int b);
    return (b >= 4) ? 4'hF : 4'((1 << b) - 1);
  endfunction

  task automatic cyc(input logic [31:0] d, input logic de, input logic df, input logic lp);
    data = d; data_enable = de; data_frame = df; lp_detect = lp;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc($urandom, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_in_frame[i] = 0; m_line[i] = 16'd0; end
    m_frame_num = 16'd0; m_ecc = 0; m_to = 0;
  endtask

  task automatic send_short(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc, input int flip);
    logic [31:0] hdr;
    hdr = mk_hdr(vc, dt, wc);
    if (flip >= 0) hdr[flip] = ~hdr[flip];
    cyc(hdr, 1'b1, 1'b1, 1'b0);
    idle(3);
    exp_done++;
    if (flip >= 0) m_ecc++;
    else if (int'(vc) < NUM_VC) begin
      if (dt == 6'h00) begin m_in_frame[vc] = 1; m_line[vc] = 16'd0; m_frame_num = wc; exp_fs++; end
      if (dt == 6'h01) begin m_in_frame[vc] = 0; exp_fe++; end
    end
  endtask

  // kind: 0 none, 1 lp on an idle cycle after n words, 2 data_frame drop after n words, 3 lp with word n
  task automatic send_long(input logic [1:0] vc, input logic [5:0] dt, input int wc, input int n,
                           input int kind, output bit accepted);
    bit stopped;
    logic [31:0] w;
    logic lp;
    int left;
    accepted = (dt inside {6'h2A, 6'h2B, 6'h2C}) && (int'(vc) < NUM_VC);
    exp_q.delete(); obs_q.delete();
    stopped = 0;
    cyc(mk_hdr(vc, dt, 16'(wc)), 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < n; k++) begin
      w  = $urandom;
      lp = (kind == 3) && (k == n - 1);
      idle($urandom_range(0, 2));
      cyc(w, 1'b1, 1'b1, lp);
      left = wc - 4 * k;
      if (k >= LIMIT) begin m_to++; stopped = 1; break; end
      if (left <= 4) begin
        if (accepted) begin exp_q.push_back({w, byte_mask(left), 1'b1, vc, dt}); m_line[vc]++; end
        stopped = 1; break;
      end
      if (lp) begin m_to++; stopped = 1; break; end
      if (accepted) exp_q.push_back({w, 4'hF, 1'b0, vc, dt});
    end
    if (!stopped && kind == 1) begin cyc($urandom, 1'b0, 1'b0, 1'b1); m_to++; end
    if (!stopped && kind == 2) begin cyc($urandom, 1'b1, 1'b0, 1'b0); m_to++; end
    exp_done++;
    idle(4);
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (sync_wait_o !== 1'b1) begin errors++; $display("FAIL reset_sync_wait: got %b want 1", sync_wait_o); end
    checks++;
    if ({packet_done_o, payload_o, payload_valid_o, payload_enable_o, payload_vc_o, payload_dt_o,
         payload_last_o, frame_start_o, frame_end_o, in_frame_o, in_line_o, line_num_o, frame_num_o,
         ecc_err_cnt_o, timeout_cnt_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: some output nonzero (payload_enable=%b in_frame=%b frame_num=%h)",
                         payload_enable_o, in_frame_o, frame_num_o);
    end
    areset_n = 1'b1;
    idle(2);
    checks++;
    if (sync_wait_o !== 1'b1 || done_cnt != 0) begin
      errors++; $display("FAIL reset_idle: sync_wait=%b done=%0d want 1/0", sync_wait_o, done_cnt);
    end
  endtask

  task automatic test_frame_start();
    logic [5:0] dts [5];
    logic [1:0] vc;
    logic [5:0] dt;
    dts = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h08};
    send_short(2'd0, 6'h00, 16'd7, -1);
    checks++;
    if (fs_cnt != 1 || in_frame_o[0] !== 1'b1 || frame_num_o !== 16'd7) begin
      errors++; $display("FAIL fs_directed: fs=%0d in_frame=%b frame_num=%0d want 1/x1/7", fs_cnt, in_frame_o, frame_num_o);
    end
    checks++;
    if (done_cnt != exp_done || sync_wait_o !== 1'b1) begin
      errors++; $display("FAIL fs_done: done=%0d sync_wait=%b want %0d/1", done_cnt, sync_wait_o, exp_done);
    end
    for (int i = 0; i < 14; i++) begin
      vc = 2'($urandom_range(0, 3));
      dt = dts[$urandom_range(0, 4)];
      send_short(vc, dt, 16'($urandom), -1);
      checks++;
      if (fs_cnt != exp_fs || fe_cnt != exp_fe || done_cnt != exp_done) begin
        errors++; $display("FAIL short_pulses pkt %0d: fs=%0d fe=%0d done=%0d want %0d/%0d/%0d",
                           i, fs_cnt, fe_cnt, done_cnt, exp_fs, exp_fe, exp_done);
      end
      checks++;
      if (in_frame_o !== {m_in_frame[1], m_in_frame[0]} || frame_num_o !== m_frame_num || sync_wait_o !== 1'b1) begin
        errors++; $display("FAIL short_state pkt %0d: in_frame=%b frame_num=%h sync=%b want %b/%h/1", i, in_frame_o,
                           frame_num_o, sync_wait_o, {m_in_frame[1], m_in_frame[0]}, m_frame_num);
      end
    end
  endtask

  task automatic test_ecc_error();
    int base_fs;
    bit [1:0] fr;
    for (int i = 0; i < 8; i++) begin
      base_fs = fs_cnt;
      fr = {m_in_frame[1], m_in_frame[0]};
      send_short(2'($urandom_range(0, 1)), 6'h00, 16'($urandom), (i == 0) ? 26 : int'($urandom_range(0, 31)));
      checks++;
      if (ecc_err_cnt_o !== 8'(m_ecc) || fs_cnt != base_fs) begin
        errors++; $display("FAIL ecc_count %0d: ecc=%0d fs_delta=%0d want %0d/0", i, ecc_err_cnt_o, fs_cnt - base_fs, m_ecc);
      end
      checks++;
      if (done_cnt != exp_done || sync_wait_o !== 1'b1 || in_frame_o !== fr) begin
        errors++; $display("FAIL ecc_done %0d: done=%0d sync=%b in_frame=%b want %0d/1/%b", i, done_cnt, sync_wait_o,
                           in_frame_o, exp_done, fr);
      end
    end
  endtask

  task automatic test_payload();
    logic [5:0] dts [3];
    logic [1:0] vc;
    logic [5:0] dt;
    int  wc;
    bit  acc;
    dts = '{6'h2A, 6'h2B, 6'h2C};
    for (int i = 0; i < 20; i++) begin
      vc = (i == 0) ? 2'd1 : 2'($urandom_range(0, 1));
      dt = (i == 0) ? 6'h2A : dts[$urandom_range(0, 2)];
      wc = (i == 0) ? 10 : int'($urandom_range(1, 60));
      send_long(vc, dt, wc, (wc + 3) / 4, 0, acc);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL payload_count pkt %0d: got %0d words want %0d", i, obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[k]) begin
          checks++;
          if (obs_q[k] !== exp_q[k]) begin
            errors++; $display("FAIL payload_word pkt %0d word %0d: got %h want %h", i, k, obs_q[k], exp_q[k]);
          end
        end
      end
      if (i == 0 && obs_q.size() == 3) begin
        checks++;
        if (obs_q[2].v !== 4'b0011 || obs_q[1].v !== 4'b1111 || obs_q[2].last !== 1'b1) begin
          errors++; $display("FAIL payload_wc10_valid: got %b/%b last=%b want 1111/0011/1", obs_q[1].v, obs_q[2].v, obs_q[2].last);
        end
      end
      checks++;
      if (done_cnt != exp_done || in_line_o !== 1'b0 || payload_vc_o !== vc || line_num_o !== m_line[vc]) begin
        errors++; $display("FAIL payload_status pkt %0d: done=%0d in_line=%b vc=%0d line=%0d want %0d/0/%0d/%0d",
                           i, done_cnt, in_line_o, payload_vc_o, line_num_o, exp_done, vc, m_line[vc]);
      end
    end
  endtask

  task automatic test_abort();
    int sc_wc [6];
    int sc_n [6];
    int sc_kind [6];
    int wc, n, kind, words;
    logic [1:0] vc;
    bit acc;
    sc_wc   = '{100, 40, 20, 40, 200, 64};
    sc_n    = '{5,   3,  5,  4,  17,  16};
    sc_kind = '{1,   2,  3,  3,  0,   0};
    for (int i = 0; i < 16; i++) begin
      vc = 2'($urandom_range(0, 1));
      if (i < 6) begin
        wc = sc_wc[i]; n = sc_n[i]; kind = sc_kind[i];
      end else begin
        wc = int'($urandom_range(1, 60));
        words = (wc + 3) / 4;
        kind = int'($urandom_range(1, 3));
        n = (kind == 3) ? int'($urandom_range(1, words)) : int'($urandom_range(0, words - 1));
      end
      send_long(vc, 6'h2A, wc, n, kind, acc);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++; $display("FAIL abort_count sc %0d: got %0d words want %0d", i, obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[k]) begin
          checks++;
          if (obs_q[k] !== exp_q[k]) begin
            errors++; $display("FAIL abort_word sc %0d word %0d: got %h want %h", i, k, obs_q[k], exp_q[k]);
          end
        end
      end
      checks++;
      if (timeout_cnt_o !== 8'(m_to) || done_cnt != exp_done || in_line_o !== 1'b0) begin
        errors++; $display("FAIL abort_status sc %0d: timeouts=%0d done=%0d in_line=%b want %0d/%0d/0",
                           i, timeout_cnt_o, done_cnt, in_line_o, m_to, exp_done);
      end
      checks++;
      if (line_num_o !== m_line[vc] || sync_wait_o !== 1'b1) begin
        errors++; $display("FAIL abort_line sc %0d: line=%0d sync=%b want %0d/1", i, line_num_o, sync_wait_o, m_line[vc]);
      end
    end
  endtask

  task automatic test_skip();
    int base;
    bit acc;
    obs_q.delete();
    base = done_cnt;
    cyc(mk_hdr(2'd0, 6'h12, 16'd8), 1'b1, 1'b1, 1'b0);
    cyc($urandom, 1'b1, 1'b1, 1'b0);
    idle(3);
    checks++;
    if (done_cnt != base) begin errors++; $display("FAIL skip_early_done: got %0d want %0d", done_cnt, base); end
    cyc($urandom, 1'b1, 1'b1, 1'b0);
    idle(3);
    exp_done++;
    checks++;
    if (done_cnt != base + 1 || obs_q.size() != 0) begin
      errors++; $display("FAIL skip_dt12: done=%0d words=%0d want %0d/0", done_cnt, obs_q.size(), base + 1);
    end
    send_long(2'd3, 6'h2A, 8, 2, 0, acc);
    checks++;
    if (obs_q.size() != 0 || done_cnt != exp_done) begin
      errors++; $display("FAIL skip_vc3: words=%0d done=%0d want 0/%0d", obs_q.size(), done_cnt, exp_done);
    end
    send_long(2'd0, 6'h30, 13, 4, 0, acc);
    checks++;
    if (obs_q.size() != 0 || done_cnt != exp_done || timeout_cnt_o !== 8'(m_to)) begin
      errors++; $display("FAIL skip_dt30: words=%0d done=%0d to=%0d want 0/%0d/%0d", obs_q.size(), done_cnt,
                         timeout_cnt_o, exp_done, m_to);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] wc;
    cyc(mk_hdr(2'd0, 6'h2A, 16'd40), 1'b1, 1'b1, 1'b0);
    repeat (3) cyc($urandom, 1'b1, 1'b1, 1'b0);
    areset_n = 1'b0;
    #1;
    checks++;
    if (sync_wait_o !== 1'b1 || {packet_done_o, payload_enable_o, in_line_o, in_frame_o, timeout_cnt_o,
                                 ecc_err_cnt_o, frame_num_o, line_num_o, payload_o} !== '0) begin
      errors++; $display("FAIL midreset_outputs: sync=%b in_line=%b payload_enable=%b in_frame=%b",
                         sync_wait_o, in_line_o, payload_enable_o, in_frame_o);
    end
    idle(2);
    areset_n = 1'b1;
    model_reset();
    idle(2);
    checks++;
    if (done_cnt != exp_done) begin errors++; $display("FAIL midreset_no_done: done=%0d want %0d", done_cnt, exp_done); end
    wc = 16'($urandom);
    send_short(2'd0, 6'h00, wc, -1);
    checks++;
    if (fs_cnt != exp_fs || in_frame_o !== 2'b01 || frame_num_o !== wc || done_cnt != exp_done) begin
      errors++; $display("FAIL midreset_fs: fs=%0d in_frame=%b frame_num=%h done=%0d want %0d/01/%h/%0d",
                         fs_cnt, in_frame_o, frame_num_o, done_cnt, exp_fs, wc, exp_done);
    end
    checks++;
    if (timeout_cnt_o !== 8'd0 || ecc_err_cnt_o !== 8'd0 || sync_wait_o !== 1'b1) begin
      errors++; $display("FAIL midreset_counters: to=%0d ecc=%0d sync=%b want 0/0/1", timeout_cnt_o, ecc_err_cnt_o, sync_wait_o);
    end
  endtask

  initial begin
    data = '0; data_enable = 1'b0; data_frame = 1'b0; lp_detect = 1'b0; areset_n = 1'b0;
    model_reset();
    exp_done = 0; exp_fs = 0; exp_fe = 0;
    test_reset();
    test_frame_start();
    test_ecc_error();
    test_payload();
    test_abort();
    test_skip();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
